// File: rtl/display_scan_rx_if.sv
// Digit/position stream from the sequencing FSM plus the display-side outputs.
interface display_scan_rx_if;
    logic [3:0] C_Digit;
    logic [3:0] C_7Seg;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_done;
    logic       frame_err;

    modport master (
        output C_Digit, C_7Seg,
        input  an, seg, frame_done, frame_err
    );

    modport slave (
        input  C_Digit, C_7Seg,
        output an, seg, frame_done, frame_err
    );
endinterface

// File: rtl/display_scan_rx.sv
// Collects a 4-digit frame from the sequencer into a shadow buffer, commits it
// atomically to the display buffer and scans it onto a common-anode display.
module display_scan_rx #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    display_scan_rx_if.slave  bus
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    // Encoding equals the digit position each state is waiting for.
    typedef enum logic [1:0] {
        WAIT_D0 = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        WAIT_D3 = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic [3:0][3:0]  disp_q, disp_d;
    logic             acc_vld_q, acc_vld_d;
    logic [1:0]       acc_pos_q, acc_pos_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic             code_idle;
    logic             code_vld;
    logic [1:0]       code_pos;
    logic [3:0]       cur_digit;

    // Decode the one-cold position code.
    always_comb begin
        code_idle = (bus.C_7Seg == 4'b1111);
        code_vld  = 1'b1;
        code_pos  = 2'd0;
        case (bus.C_7Seg)
            4'b0111: code_pos = 2'd3;
            4'b1011: code_pos = 2'd2;
            4'b1101: code_pos = 2'd1;
            4'b1110: code_pos = 2'd0;
            default: code_vld = 1'b0;
        endcase
    end

    // Receive FSM: hold check has priority over in-order acceptance.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        acc_vld_d = 1'b0;
        acc_pos_d = acc_pos_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (code_idle) begin
            acc_vld_d = 1'b0;
        end else if (!code_vld) begin
            err_d   = 1'b1;
            state_d = WAIT_D3;
        end else if (acc_vld_q && (code_pos == acc_pos_q)) begin
            shadow_d[code_pos] = bus.C_Digit;
            acc_vld_d          = 1'b1;
        end else if (state_t'(code_pos) == state_q) begin
            shadow_d[code_pos] = bus.C_Digit;
            acc_vld_d          = 1'b1;
            acc_pos_d          = code_pos;
            if (state_q == WAIT_D0) begin
                disp_d    = shadow_q;
                disp_d[0] = bus.C_Digit;
                done_d    = 1'b1;
                state_d   = WAIT_D3;
            end else begin
                state_d = state_t'(2'(state_q) - 2'd1);
            end
        end else begin
            err_d = 1'b1;
            if (code_pos == 2'd3) begin
                shadow_d[3] = bus.C_Digit;
                acc_vld_d   = 1'b1;
                acc_pos_d   = 2'd3;
                state_d     = WAIT_D2;
            end else begin
                state_d = WAIT_D3;
            end
        end
    end

    // Refresh counter and scan index, independent of frame activity.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Anode select and glyph lookup for the currently scanned digit.
    always_comb begin
        an_d      = ~(4'b0001 << idx_q);
        cur_digit = disp_q[idx_q];
        seg_d     = 7'b1111111;
        case (cur_digit)
            4'h0: seg_d = 7'b1000000;
            4'h1: seg_d = 7'b1111001;
            4'h2: seg_d = 7'b0100100;
            4'h3: seg_d = 7'b0110000;
            4'h4: seg_d = 7'b0011001;
            4'h5: seg_d = 7'b0010010;
            4'h6: seg_d = 7'b0000010;
            4'h7: seg_d = 7'b1111000;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0010000;
            4'hF: seg_d = 7'b1111111;
            default: seg_d = 7'b0111111;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_D3;
            shadow_q  <= '1;
            disp_q    <= '1;
            acc_vld_q <= 1'b0;
            acc_pos_q <= 2'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            an_q      <= '1;
            seg_q     <= '1;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            acc_vld_q <= acc_vld_d;
            acc_pos_q <= acc_pos_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;

endmodule
